matrix_addn_tile_sched: RTL
===========================

# matrix_addn_tile_sched

Tile scheduler for the 4×4 LUT-based matrix adder (`matrix_addN`). It accepts a job describing a matrix of up to 8×8 tiles, each tile 4×4, stored tile-per-word in three memories. It streams tile reads of A and B into the adder one per cycle and tracks the adder pipeline latency. It writes each C tile back and holds the adder/LUT configuration (`m_bit1`, `m_bit2`, `flag`) stable for the whole job. It sits between the job-issuing control logic and the `matrix_addN` instance plus its operand/result tile memories. Operand data paths wire directly memory→adder→memory; this block drives only control and addresses.

## Interface
Parameters:
- `width`, 16: element half-width, matching the adder (not used internally; passed for consistency).
- `TILE_AW`, 8: tile address width of the A/B/C tile memories.
- `LAT`, 2: adder latency in cycles, from operand tile stable at adder input to C tile valid at adder output; legal range 1..7.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  high only in IDLE and while `rst` is low.
- `job_tr`  in  3  tile rows minus 1.
- `job_tc`  in  3  tile columns minus 1.
- `job_base_a`, `job_base_b`, `job_base_c`  in  TILE_AW  base tile addresses.
- `job_m_bit1`, `job_m_bit2`  in  5  adder LUT configuration.
- `job_flag`  in  1  adder mode flag.
- `add_m_bit1`, `add_m_bit2`  out  5  registered config to adder.
- `add_flag`  out  1  registered flag to adder.
- `rd_en`  out  1  read strobe for A and B memories; read latency 1 cycle.
- `rd_addr_a`, `rd_addr_b`  out  TILE_AW.
- `wr_en`  out  1  write strobe for C memory.
- `wr_addr_c`  out  TILE_AW.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at job completion.
- `tiles_done`  out  7  count of C tiles written in the current job.

## Operation
- State machine:
  - IDLE → ISSUE on `job_valid && job_ready`. On that edge, capture all `job_*` fields, set N = (tr+1)·(tc+1) (1..64), clear the issue index and `tiles_done`, and load `add_m_bit1`, `add_m_bit2`, `add_flag`.
  - ISSUE: assert `rd_en` for one cycle per tile, idx = 0..N-1 in row-major order. `rd_addr_x = base_x + idx`, truncated to TILE_AW, so it wraps modulo 2^TILE_AW. After the cycle with idx = N-1, go to DRAIN.
  - DRAIN: no reads. When the write pipeline is empty after the last `wr_en`, go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Write tracking: a shift register of depth LAT+1 carries (valid, base_c + idx). The entry enqueued with a read emerges LAT+1 cycles later as `wr_en` and `wr_addr_c`. The 1 accounts for memory read latency; LAT is the adder latency. `tiles_done` increments on each `wr_en`.
- Config outputs change only on job accept, never mid-job. Since a new job is accepted only in IDLE, every tile of a job uses one configuration, and the shared LUT is never reconfigured while tiles are in flight.
- `job_valid` outside IDLE is ignored; the requester holds it until `job_ready`.
- `wr_addr_c` wraps like the read addresses. Address overlap between A/B and C is not checked; that is the caller's responsibility.

## Timing
- Reset: all outputs 0 while `rst` is high, including `job_ready`. The state goes to IDLE, the shift register clears, and `tiles_done` = 0. `job_ready` = 1 on the first cycle after `rst` falls.
- `rst` mid-job aborts the job. In-flight tiles are discarded, with no `wr_en` after the reset edge and no `done`.
- Accept at cycle 0:
  - `rd_en` in cycles 1..N.
  - `wr_en` in cycles LAT+2 .. N+LAT+1.
  - `done` in cycle N+LAT+2.
  - `job_ready` in cycle N+LAT+3.
- Throughput is one tile per cycle. Job overhead is LAT+3 cycles.
- `rd_addr_*` and `wr_addr_c` are only meaningful while their strobe is high. They are 0 otherwise.

## Test plan
- 1 tile (tr=0, tc=0), base_a=0x10, base_b=0x20, base_c=0x30, LAT=2, accept at cycle 0 → `rd_en` cycle 1 (A=0x10, B=0x20); `wr_en` cycle 4 with addr 0x30; `done` cycle 5; `job_ready` cycle 6; `tiles_done`=1.
- Full 8×8 tiles (tr=tc=7), bases 0 → 64 consecutive reads at cycles 1..64 with addresses 0..63; writes at cycles 4..67; `done` at 68; `tiles_done`=64.
- Wrap: tr=0, tc=3, base_a=0xFE → `rd_addr_a` sequence FE, FF, 00, 01. With base_c=0xFF, `wr_addr_c` sequence is FF, 00, 01, 02.
- Config hold: accept with m_bit1=5, m_bit2=9, flag=1, then change the `job_*` inputs to 3/4/0 while busy → `add_*` stays 5/9/1 until `done`. A new accept then loads 3/4/0.
- Back-pressure: `job_valid` held high across two jobs (N=2 each) → the second accept occurs exactly at the cycle `job_ready` returns. No read from job 2 precedes job 1's `done`.
- Reset mid-job: 64-tile job, `rst` high in cycle 10 → from cycle 11 all outputs are 0. No `wr_en` or `done` appears afterward. `job_ready`=1 one cycle after `rst` falls.

Source files
------------

// File: rtl/matrix_addn_tile_sched.sv
// Tile scheduler for the 4x4 matrix adder: streams A/B tile reads, tracks adder
// latency with a valid/address shift register and writes C tiles back.
module matrix_addn_tile_sched #(
  parameter int width   = 16,
  parameter int TILE_AW = 8,
  parameter int LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [2:0]         job_tr,
  input  logic [2:0]         job_tc,
  input  logic [TILE_AW-1:0] job_base_a,
  input  logic [TILE_AW-1:0] job_base_b,
  input  logic [TILE_AW-1:0] job_base_c,
  input  logic [4:0]         job_m_bit1,
  input  logic [4:0]         job_m_bit2,
  input  logic               job_flag,
  output logic [4:0]         add_m_bit1,
  output logic [4:0]         add_m_bit2,
  output logic               add_flag,
  output logic               rd_en,
  output logic [TILE_AW-1:0] rd_addr_a,
  output logic [TILE_AW-1:0] rd_addr_b,
  output logic               wr_en,
  output logic [TILE_AW-1:0] wr_addr_c,
  output logic               busy,
  output logic               done,
  output logic [6:0]         tiles_done
);

  if (LAT < 1 || LAT > 7 || width < 1) begin : g_bad_params
    $error("matrix_addn_tile_sched: LAT must be in 1..7 and width positive");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [5:0]         idx;
  logic [5:0]         last_idx;
  logic [5:0]         job_last;
  logic [TILE_AW-1:0] base_a_q;
  logic [TILE_AW-1:0] base_b_q;
  logic [TILE_AW-1:0] base_c_q;
  logic [4:0]         m_bit1_q;
  logic [4:0]         m_bit2_q;
  logic               flag_q;
  logic [6:0]         tiles_q;
  logic               issue_now;
  logic               write_now;
  logic [LAT:0]       pipe_v;
  logic [TILE_AW-1:0] pipe_addr [LAT+1];

  // (tr+1)*(tc+1)-1 taken modulo 64 gives the last index directly, 63 for an 8x8 job.
  assign job_last  = ({3'b000, job_tr} + 6'd1) * ({3'b000, job_tc} + 6'd1) - 6'd1;
  assign issue_now = (state == ISSUE);
  assign write_now = pipe_v[LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      m_bit1_q <= '0;
      m_bit2_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            state    <= ISSUE;
            idx      <= '0;
            last_idx <= job_last;
            base_a_q <= job_base_a;
            base_b_q <= job_base_b;
            base_c_q <= job_base_c;
            m_bit1_q <= job_m_bit1;
            m_bit2_q <= job_m_bit2;
            flag_q   <= job_flag;
          end
        end
        ISSUE: begin
          idx <= idx + 6'd1;
          if (idx == last_idx) state <= DRAIN;
        end
        // Only the final stage may still be occupied: its write happens this cycle.
        DRAIN: begin
          if (pipe_v[LAT-1:0] == '0) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i <= LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_v       <= {pipe_v[LAT-1:0], issue_now};
      pipe_addr[0] <= base_c_q + TILE_AW'(idx);
      for (int i = 1; i <= LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tiles_q <= '0;
    end else if (state == IDLE && job_valid) begin
      tiles_q <= '0;
    end else if (write_now) begin
      tiles_q <= tiles_q + 7'd1;
    end
  end

  // Every output is forced low while reset is asserted, including the handshake.
  assign job_ready  = (state == IDLE) && !rst;
  assign busy       = (state != IDLE) && !rst;
  assign done       = (state == DONE) && !rst;
  assign rd_en      = issue_now && !rst;
  assign rd_addr_a  = rd_en ? base_a_q + TILE_AW'(idx) : '0;
  assign rd_addr_b  = rd_en ? base_b_q + TILE_AW'(idx) : '0;
  assign wr_en      = write_now && !rst;
  assign wr_addr_c  = wr_en ? pipe_addr[LAT] : '0;
  assign add_m_bit1 = rst ? '0 : m_bit1_q;
  assign add_m_bit2 = rst ? '0 : m_bit2_q;
  assign add_flag   = flag_q && !rst;
  assign tiles_done = rst ? '0 : tiles_q;

endmodule
